// File: rtl/multicycle_sequencer_if.sv
// Memory handshake between the sequencer (master) and the shared single-port memory (slave).
// mem_ready completes the access in the same cycle it is seen with mem_req high.
interface multicycle_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with illegal-opcode and memory-timeout detection parking the block in TRAP.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   multicycle_sequencer_if.master       mem,
   input  logic [6:0]                   opcode,
   input  logic                         alu_zero,
   output logic                         ir_write,
   output logic                         pc_write,
   output logic [1:0]                   pc_src,
   output logic                         reg_write,
   output logic [1:0]                   wb_sel,
   output logic                         retire,
   output logic                         trap,
   output logic                         trap_cause,
   output logic [2:0]                   state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_ALU     = 3'd0,
      C_LOAD    = 3'd1,
      C_STORE   = 3'd2,
      C_BRANCH  = 3'd3,
      C_JAL     = 3'd4,
      C_JALR    = 3'd5,
      C_ILLEGAL = 3'd6
   } op_class_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

   state_t    state_q, state_d;
   op_class_t class_q, class_d, dec_class;
   logic [7:0] wait_q, wait_d;
   logic       cause_q, cause_d;

   logic       mem_req_c, mem_we_c, mem_addr_sel_c;
   logic       ir_write_c, pc_write_c, reg_write_c, retire_c, trap_c;
   logic [1:0] pc_src_c, wb_sel_c;

   // R-type, I-arith, LUI and AUIPC share one class: they all write the ALU result.
   always_comb begin
      dec_class = C_ILLEGAL;
      case (opcode)
         7'b0110011, 7'b0010011,
         7'b0110111, 7'b0010111: dec_class = C_ALU;
         7'b0000011:             dec_class = C_LOAD;
         7'b0100011:             dec_class = C_STORE;
         7'b1100011:             dec_class = C_BRANCH;
         7'b1101111:             dec_class = C_JAL;
         7'b1100111:             dec_class = C_JALR;
         default:                dec_class = C_ILLEGAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         class_q <= C_ALU;
         wait_q  <= 8'd0;
         cause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      class_d        = class_q;
      wait_d         = wait_q;
      cause_d        = cause_q;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = 2'b00;
      reg_write_c    = 1'b0;
      wb_sel_c       = 2'b00;
      retire_c       = 1'b0;
      trap_c         = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem.mem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (wait_q == WAIT_LIMIT) begin
               state_d = S_TRAP;
               cause_d = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_DECODE: begin
            if (dec_class == C_ILLEGAL) begin
               state_d = S_TRAP;
               cause_d = 1'b1;
            end else begin
               class_d = dec_class;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            case (class_q)
               C_BRANCH: begin
                  pc_write_c = 1'b1;
                  pc_src_c   = alu_zero ? 2'b01 : 2'b00;
                  retire_c   = 1'b1;
                  state_d    = S_FETCH;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end

         S_MEM: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = (class_q == C_STORE);
            if (mem.mem_ready) begin
               if (class_q == C_STORE) begin
                  pc_write_c = 1'b1;
                  retire_c   = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LIMIT) begin
               state_d = S_TRAP;
               cause_d = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_WB: begin
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
            case (class_q)
               C_LOAD:  wb_sel_c = 2'b01;
               C_JAL: begin
                  wb_sel_c = 2'b10;
                  pc_src_c = 2'b01;
               end
               C_JALR: begin
                  wb_sel_c = 2'b10;
                  pc_src_c = 2'b10;
               end
               default: wb_sel_c = 2'b00;
            endcase
         end

         S_TRAP: trap_c = 1'b1;

         default: state_d = S_FETCH;
      endcase

      // The wait counter measures one access only, so any state change restarts it.
      if (state_d != state_q) wait_d = 8'd0;
   end

   assign mem.mem_req      = mem_req_c      & ~rst;
   assign mem.mem_we       = mem_we_c       & ~rst;
   assign mem.mem_addr_sel = mem_addr_sel_c & ~rst;
   assign ir_write         = ir_write_c     & ~rst;
   assign pc_write         = pc_write_c     & ~rst;
   assign pc_src           = rst ? 2'b00 : pc_src_c;
   assign reg_write        = reg_write_c    & ~rst;
   assign wb_sel           = rst ? 2'b00 : wb_sel_c;
   assign retire           = retire_c       & ~rst;
   assign trap             = trap_c         & ~rst;
   assign trap_cause       = cause_q        & ~rst;
   assign state            = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle control-vector checks from a small model,
// plus a latency scoreboard popped on every retire.
module tb_multicycle_sequencer;

   localparam int TO = 15;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       alu_zero;
   logic       ir_write, pc_write, reg_write, retire, trap, trap_cause;
   logic [1:0] pc_src, wb_sel;
   logic [2:0] state;

   multicycle_sequencer_if mem_if ();

   multicycle_sequencer #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem        (mem_if.master),
      .opcode     (opcode),
      .alu_zero   (alu_zero),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .wb_sel     (wb_sel),
      .retire     (retire),
      .trap       (trap),
      .trap_cause (trap_cause),
      .state      (state)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic       model_cause = 1'b0;
   logic [7:0] exp_q[$];
   int         cyc = 0;
   logic [6:0] legal_ops[9];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // {state, trap, trap_cause, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel, retire}
   function automatic logic [15:0] obs();
      return {state, trap, trap_cause, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel,
              ir_write, pc_write, pc_src, reg_write, wb_sel, retire};
   endfunction

   function automatic logic [15:0] ev(input logic [2:0] st, input logic req, input logic we,
                                      input logic asel, input logic irw, input logic pcw,
                                      input logic [1:0] pcs, input logic rw,
                                      input logic [1:0] wbs, input logic ret);
      return {st, (st == 3'd7), model_cause, req, we, asel, irw, pcw, pcs, rw, wbs, ret};
   endfunction

   // scoreboard: every retire pops the expected instruction latency
   always @(negedge clk) begin
      if (rst) begin
         cyc = 0;
      end else begin
         cyc++;
         if (retire === 1'b1) begin
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else check("latency", cyc, exp_q.pop_front());
            cyc = 0;
         end else if (trap === 1'b1) begin
            cyc = 0;
         end
      end
   end

   // driver tasks
   task automatic step(input string tag, input logic rdy, input logic [15:0] exp);
      mem_if.mem_ready = rdy;
      @(negedge clk);
      check(tag, obs(), exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_if.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out", obs(), 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_cause = 1'b0;
   endtask

   task automatic trap_hold(input string tag, input int n);
      for (int i = 0; i < n; i++)
         step(tag, 1'($urandom_range(0, 1)), ev(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
      do_reset();
   endtask

   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
      bit is_alu, is_ld, is_st, is_br, is_jal, is_jalr, legal, lsu, done;
      logic [1:0] pcs, wbs;
      int lat;
      is_alu  = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0110111) || (op == 7'b0010111);
      is_ld   = (op == 7'b0000011);
      is_st   = (op == 7'b0100011);
      is_br   = (op == 7'b1100011);
      is_jal  = (op == 7'b1101111);
      is_jalr = (op == 7'b1100111);
      legal   = is_alu || is_ld || is_st || is_br || is_jal || is_jalr;
      lsu     = is_ld || is_st;
      lat     = (is_br ? 3 : (is_ld ? 5 : 4)) + fw + (lsu ? mw : 0);
      if (legal && fw < TO && (!lsu || mw < TO)) exp_q.push_back(8'(lat));
      done = 0;

      opcode   = op;
      alu_zero = z;
      if (fw >= TO) begin
         for (int i = 0; i < TO; i++) step("fetch_wait", 1'b0, ev(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
         model_cause = 1'b0;
         trap_hold("fetch_timeout", 5);
         done = 1;
      end
      if (!done) begin
         for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, ev(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
         step("fetch", 1'b1, ev(3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0));
         step("decode", 1'($urandom_range(0, 1)), ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
         if (!legal) begin
            model_cause = 1'b1;
            trap_hold("illegal_trap", 20);
            done = 1;
         end
      end
      if (!done) begin
         // the IR may change after DECODE; the latched class must still be used
         opcode = 7'($urandom_range(0, 127));
         if (is_br) begin
            step("exec_br", 1'($urandom_range(0, 1)), ev(3'd2, 0, 0, 0, 0, 1, {1'b0, z}, 0, 2'b00, 1));
            done = 1;
         end else begin
            step("exec", 1'($urandom_range(0, 1)), ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
         end
      end
      if (!done && lsu) begin
         if (mw >= TO) begin
            for (int i = 0; i < TO; i++) step("mem_wait", 1'b0, ev(3'd3, 1, is_st, 1, 0, 0, 2'b00, 0, 2'b00, 0));
            model_cause = 1'b0;
            trap_hold("mem_timeout", 5);
            done = 1;
         end else begin
            for (int i = 0; i < mw; i++) step("mem_wait", 1'b0, ev(3'd3, 1, is_st, 1, 0, 0, 2'b00, 0, 2'b00, 0));
            step("mem", 1'b1, ev(3'd3, 1, is_st, 1, 0, is_st, 2'b00, 0, 2'b00, is_st));
            if (is_st) done = 1;
         end
      end
      if (!done) begin
         pcs = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
         wbs = is_ld ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
         step("wb", 1'($urandom_range(0, 1)), ev(3'd4, 0, 0, 0, 0, 1, pcs, 1, wbs, 1));
      end
   endtask

   initial begin
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      rst = 1'b1;
      opcode = 7'd0;
      alu_zero = 1'b0;
      mem_if.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      run_instr(7'b0110011, 0, 0, 1'b0);   // ADD
      run_instr(7'b0000011, 2, 3, 1'b0);   // LW with waits
      run_instr(7'b1100011, 0, 0, 1'b1);   // BEQ taken
      run_instr(7'b1100011, 0, 0, 1'b0);   // BEQ not taken
      run_instr(7'b1100111, 0, 0, 1'b0);   // JALR
      run_instr(7'b0100011, 0, 0, 1'b0);   // SW
      run_instr(7'b1101111, 1, 0, 1'b0);   // JAL
      run_instr(7'b0110111, 0, 0, 1'b1);   // LUI
      run_instr(7'b0000000, 0, 0, 1'b0);   // illegal
      run_instr(7'b0110011, TO, 0, 1'b0);  // fetch timeout
      run_instr(7'b0110011, TO - 1, 0, 1'b0); // ready on the last allowed cycle
      run_instr(7'b0000011, 0, TO, 1'b0);  // MEM timeout on a load
      run_instr(7'b0100011, 0, TO - 1, 1'b0);

      // reset in the middle of a fetch abandons the access
      opcode = 7'b0000011;
      step("abort_wait", 1'b0, ev(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
      do_reset();

      for (int n = 0; n < 40; n++)
         run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      run_instr(7'b1111111, 0, 0, 1'b0);
      run_instr(7'b0010011, 0, 0, 1'b0);

      @(negedge clk);
      check("sb_left", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
